// File: rtl/action_fetch.sv
// Holds PHVs in arrival order until their lookup result arrives, then emits each PHV with its action word.
// Optional hit/miss counters are built when ACTION_FETCH_STATS_EN is defined.
module action_fetch #(
  parameter int PHV_LEN    = 1124,
  parameter int ACT_LEN    = 25,
  parameter int FIFO_DEPTH = 8,
  parameter int ACT_ADDR_W = 5
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [PHV_LEN-1:0]             phv_in,
  input  logic                           phv_in_valid,
  input  logic                           lookup_valid,
  input  logic                           lookup_hit,
  input  logic [ACT_ADDR_W-1:0]          lookup_addr,
  input  logic                           act_wr_en,
  input  logic [ACT_ADDR_W-1:0]          act_wr_addr,
  input  logic [ACT_LEN*25-1:0]          act_wr_data,
  output logic [PHV_LEN-1:0]             phv_out,
  output logic                           phv_out_valid,
  output logic [ACT_LEN*25-1:0]          action_out,
  output logic                           action_out_valid,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_count,
  output logic                           err_overflow,
`ifdef ACTION_FETCH_STATS_EN
  output logic [31:0]                    hit_cnt,
  output logic [31:0]                    miss_cnt,
`endif
  output logic                           err_underflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ACT_W = ACT_LEN * 25;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic [PHV_LEN-1:0] fifo_mem [FIFO_DEPTH];
  logic [ACT_W-1:0]   act_ram  [2**ACT_ADDR_W];

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PHV_LEN-1:0] phv_out_q, phv_out_d;
  logic [ACT_W-1:0]   act_out_q, act_out_d;
  logic               vld_q, vld_d;
  logic               ovf_q, ovf_d, unf_q, unf_d;
  logic               empty, full, pop, push;

  // A PHV pushed into an empty FIFO is not poppable in the same cycle
  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);
  assign pop   = lookup_valid & ~empty;
  assign push  = phv_in_valid & (~full | pop);

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    phv_out_d = phv_out_q;
    act_out_d = act_out_q;
    vld_d     = pop;
    ovf_d     = ovf_q | (phv_in_valid & full & ~pop);
    unf_d     = unf_q | (lookup_valid & empty);
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      phv_out_d = fifo_mem[rd_ptr_q];
      act_out_d = lookup_hit ? act_ram[lookup_addr] : '0;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      phv_out_q <= '0;
      act_out_q <= '0;
      vld_q     <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      phv_out_q <= phv_out_d;
      act_out_q <= act_out_d;
      vld_q     <= vld_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  // Storage arrays carry no reset; a same-cycle RAM read sees the pre-write word
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= phv_in;
  end

  always_ff @(posedge clk) begin
    if (act_wr_en) act_ram[act_wr_addr] <= act_wr_data;
  end

`ifdef ACTION_FETCH_STATS_EN
  logic [31:0] hit_q, hit_d, miss_q, miss_d;

  always_comb begin
    hit_d  = hit_q;
    miss_d = miss_q;
    if (pop &  lookup_hit && hit_q  != 32'hFFFF_FFFF) hit_d  = hit_q + 32'd1;
    if (pop & ~lookup_hit && miss_q != 32'hFFFF_FFFF) miss_d = miss_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      hit_q  <= hit_d;
      miss_q <= miss_d;
    end
  end

  assign hit_cnt  = hit_q;
  assign miss_cnt = miss_q;
`endif

  assign phv_out          = phv_out_q;
  assign phv_out_valid    = vld_q;
  assign action_out       = act_out_q;
  assign action_out_valid = vld_q;
  assign fifo_count       = count_q;
  assign err_overflow     = ovf_q;
  assign err_underflow    = unf_q;

endmodule

// File: tb/tb_action_fetch.sv
// Directed bench for action_fetch: ordering, latency, miss zeroing, full/empty corners, reset, RAM read-before-write.
module tb_action_fetch;
  localparam int PHV_LEN    = 1124;
  localparam int ACT_LEN    = 25;
  localparam int FIFO_DEPTH = 8;
  localparam int ACT_ADDR_W = 5;
  localparam int ACT_W      = ACT_LEN * 25;

  logic                  clk;
  logic                  rst_n;
  logic [PHV_LEN-1:0]    phv_in;
  logic                  phv_in_valid;
  logic                  lookup_valid;
  logic                  lookup_hit;
  logic [ACT_ADDR_W-1:0] lookup_addr;
  logic                  act_wr_en;
  logic [ACT_ADDR_W-1:0] act_wr_addr;
  logic [ACT_W-1:0]      act_wr_data;
  logic [PHV_LEN-1:0]    phv_out;
  logic                  phv_out_valid;
  logic [ACT_W-1:0]      action_out;
  logic                  action_out_valid;
  logic [3:0]            fifo_count;
  logic                  err_overflow;
  logic                  err_underflow;
`ifdef ACTION_FETCH_STATS_EN
  logic [31:0]           hit_cnt;
  logic [31:0]           miss_cnt;
`endif

  int checks = 0;
  int errors = 0;

  action_fetch #(
    .PHV_LEN(PHV_LEN), .ACT_LEN(ACT_LEN), .FIFO_DEPTH(FIFO_DEPTH), .ACT_ADDR_W(ACT_ADDR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .phv_in(phv_in), .phv_in_valid(phv_in_valid),
    .lookup_valid(lookup_valid), .lookup_hit(lookup_hit), .lookup_addr(lookup_addr),
    .act_wr_en(act_wr_en), .act_wr_addr(act_wr_addr), .act_wr_data(act_wr_data),
    .phv_out(phv_out), .phv_out_valid(phv_out_valid),
    .action_out(action_out), .action_out_valid(action_out_valid),
    .fifo_count(fifo_count), .err_overflow(err_overflow),
`ifdef ACTION_FETCH_STATS_EN
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
`endif
    .err_underflow(err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [PHV_LEN-1:0] pat(input int k);
    logic [1151:0] t;
    t = {36{32'h5A5A_0000 ^ (32'(k) * 32'h0101_0101 + 32'(k))}};
    return t[PHV_LEN-1:0];
  endfunction

  task automatic chk(input string tag, input logic [PHV_LEN-1:0] obs, input logic [PHV_LEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h required=%0h (low 128 bits)", tag, obs[127:0], exp[127:0]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    phv_in_valid = 1'b0;
    lookup_valid = 1'b0;
    lookup_hit   = 1'b0;
    act_wr_en    = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [PHV_LEN-1:0] phv, input logic [ACT_W-1:0] act,
                         input logic vld, input int cnt);
    chk({tag, "_phv"}, phv_out, phv);
    chk({tag, "_act"}, PHV_LEN'(action_out), PHV_LEN'(act));
    chk({tag, "_pvld"}, PHV_LEN'(phv_out_valid), PHV_LEN'(vld));
    chk({tag, "_avld"}, PHV_LEN'(action_out_valid), PHV_LEN'(vld));
    chk({tag, "_cnt"}, PHV_LEN'(fifo_count), PHV_LEN'(cnt));
  endtask

  task automatic wr_ram(input int addr, input logic [ACT_W-1:0] data);
    act_wr_en = 1'b1; act_wr_addr = ACT_ADDR_W'(addr); act_wr_data = data;
    tick();
    act_wr_en = 1'b0;
  endtask

  task automatic lookup(input logic hit, input int addr);
    lookup_valid = 1'b1; lookup_hit = hit; lookup_addr = ACT_ADDR_W'(addr);
    tick();
    lookup_valid = 1'b0; lookup_hit = 1'b0;
  endtask

  initial begin
    logic [ACT_W-1:0] r0, r1, oldv, newv;
    r0   = ACT_W'(128'h0123_4567_89AB_CDEF_1111_2222_3333_4444);
    r1   = {ACT_W{1'b1}};
    oldv = ACT_W'(64'hDEAD_BEEF_0000_0005);
    newv = ACT_W'(64'hFACE_0000_5555_0005);
    idle();
    phv_in = '0; lookup_addr = '0; act_wr_addr = '0; act_wr_data = '0;
    rst_n = 1'b0;
    tick(); tick();
    chk_out("rst", '0, '0, 1'b0, 0);
    chk("rst_ovf", PHV_LEN'(err_overflow), '0);
    chk("rst_unf", PHV_LEN'(err_underflow), '0);
    rst_n = 1'b1;
    tick();

    // Single hit with two idle cycles between push and lookup
    wr_ram(3, ACT_W'(16'h1ABC));
    phv_in = pat(100); phv_in_valid = 1'b1;
    tick();
    idle();
    chk("t1_cnt", PHV_LEN'(fifo_count), PHV_LEN'(1));
    tick(); tick();
    chk_out("t1_idle", '0, '0, 1'b0, 1);
    lookup(1'b1, 3);
    chk_out("t1_out", pat(100), ACT_W'(16'h1ABC), 1'b1, 0);
    tick();
    chk_out("t1_hold", pat(100), ACT_W'(16'h1ABC), 1'b0, 0);

    // In-order miss / hit / hit
    wr_ram(0, r0);
    wr_ram(1, r1);
    for (int i = 0; i < 3; i++) begin
      phv_in = pat(200 + i); phv_in_valid = 1'b1;
      tick();
      chk("t2_fill", PHV_LEN'(fifo_count), PHV_LEN'(i + 1));
    end
    idle();
    lookup(1'b0, 1);
    chk_out("t2_a", pat(200), '0, 1'b1, 2);
    lookup(1'b1, 0);
    chk_out("t2_b", pat(201), r0, 1'b1, 1);
    lookup(1'b1, 1);
    chk_out("t2_c", pat(202), r1, 1'b1, 0);

    // Full FIFO: simultaneous push and pop keeps count at 8 with no error
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      phv_in = pat(300 + i); phv_in_valid = 1'b1;
      tick();
    end
    chk("t4_full", PHV_LEN'(fifo_count), PHV_LEN'(8));
    phv_in = pat(308); phv_in_valid = 1'b1;
    lookup(1'b0, 0);
    idle();
    chk_out("t4_pp", pat(300), '0, 1'b1, 8);
    chk("t4_ovf", PHV_LEN'(err_overflow), '0);
    for (int i = 1; i <= FIFO_DEPTH; i++) begin
      lookup(1'b0, 0);
      chk_out("t4_drain", pat(300 + i), '0, 1'b1, FIFO_DEPTH - i);
    end

    // Overflow: ninth push is dropped and never emitted
    for (int i = 0; i < 9; i++) begin
      phv_in = pat(400 + i); phv_in_valid = 1'b1;
      tick();
      if (i == 7) chk("t3_ovf_pre", PHV_LEN'(err_overflow), '0);
    end
    idle();
    chk("t3_cnt", PHV_LEN'(fifo_count), PHV_LEN'(8));
    chk("t3_ovf", PHV_LEN'(err_overflow), PHV_LEN'(1));
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      lookup(1'b0, 0);
      chk_out("t3_drain", pat(400 + i), '0, 1'b1, FIFO_DEPTH - 1 - i);
    end

    // Underflow: lookup on empty with a same-cycle push does not pop it
    chk("t5_unf_pre", PHV_LEN'(err_underflow), '0);
    phv_in = pat(500); phv_in_valid = 1'b1;
    lookup(1'b1, 3);
    idle();
    chk_out("t5_empty", pat(407), '0, 1'b0, 1);
    chk("t5_unf", PHV_LEN'(err_underflow), PHV_LEN'(1));
    lookup(1'b0, 0);
    chk_out("t5_late", pat(500), '0, 1'b1, 0);

    // Asynchronous reset mid-stream
    phv_in = pat(600); phv_in_valid = 1'b1;
    tick();
    phv_in = pat(601);
    tick();
    idle();
    chk("t5_cnt2", PHV_LEN'(fifo_count), PHV_LEN'(2));
    rst_n = 1'b0;
    #1;
    chk_out("t5_arst", '0, '0, 1'b0, 0);
    chk("t5_arst_ovf", PHV_LEN'(err_overflow), '0);
    chk("t5_arst_unf", PHV_LEN'(err_underflow), '0);
    tick();
    rst_n = 1'b1;
    tick();
    lookup(1'b1, 3);
    chk_out("t5_post", '0, '0, 1'b0, 0);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();

    // Same-address write during read returns old data; RAM survives reset
    chk("t6_ram_kept_unf", PHV_LEN'(err_underflow), '0);
    wr_ram(5, oldv);
    phv_in = pat(700); phv_in_valid = 1'b1;
    tick();
    phv_in = pat(701);
    tick();
    phv_in = pat(702);
    tick();
    idle();
    act_wr_en = 1'b1; act_wr_addr = 5; act_wr_data = newv;
    lookup(1'b1, 5);
    act_wr_en = 1'b0;
    chk_out("t6_old", pat(700), oldv, 1'b1, 2);
    lookup(1'b1, 5);
    chk_out("t6_new", pat(701), newv, 1'b1, 1);
    lookup(1'b1, 3);
    chk_out("t6_keep", pat(702), ACT_W'(16'h1ABC), 1'b1, 0);
    phv_in = pat(703); phv_in_valid = 1'b1;
    tick();
    idle();
    lookup(1'b0, 5);
    chk_out("t6_miss", pat(703), '0, 1'b1, 0);
`ifdef ACTION_FETCH_STATS_EN
    chk("t6_hits", PHV_LEN'(hit_cnt), PHV_LEN'(3));
    chk("t6_miss_cnt", PHV_LEN'(miss_cnt), PHV_LEN'(1));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/action_fetch.md
ACTION_FETCH -- requirements
Module: action_fetch

Interface
REQ-001 Parameter PHV_LEN, 1124, PHV width in bits (8x48 + 8x32 + 8x16 containers + 356 remaining bits).
REQ-002 Parameter ACT_LEN, 25, width of one per-container action; the full action word is ACT_LEN*25 = 625 bits.
REQ-003 Parameter FIFO_DEPTH, 8, number of PHV holding slots; SHALL be a power of two.
REQ-004 Parameter ACT_ADDR_W, 5, action RAM address width; the RAM holds 2**ACT_ADDR_W words.
REQ-005 clk  in  1  clock; all logic is rising-edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 phv_in  in  PHV_LEN  PHV from the parser or previous stage.
REQ-008 phv_in_valid  in  1  phv_in is present this cycle.
REQ-009 lookup_valid  in  1  lookup result for the oldest pending PHV is present.
REQ-010 lookup_hit  in  1  1 = match, 0 = miss.
REQ-011 lookup_addr  in  ACT_ADDR_W  action RAM index for a hit.
REQ-012 act_wr_en  in  1  action RAM write strobe from the control path.
REQ-013 act_wr_addr  in  ACT_ADDR_W  action RAM write index.
REQ-014 act_wr_data  in  ACT_LEN*25  action RAM write data.
REQ-015 phv_out  out  PHV_LEN  PHV to the crossbar.
REQ-016 phv_out_valid  out  1  phv_out is valid this cycle.
REQ-017 action_out  out  ACT_LEN*25  action word aligned with phv_out.
REQ-018 action_out_valid  out  1  asserted in the same cycle as phv_out_valid.
REQ-019 fifo_count  out  log2(FIFO_DEPTH)+1  number of PHVs currently held.
REQ-020 err_overflow  out  1  sticky; a PHV was dropped because the FIFO was full.
REQ-021 err_underflow  out  1  sticky; lookup_valid arrived while the FIFO was empty.

Function
REQ-022 Each phv_in_valid pushes phv_in into an in-order FIFO; lookup results are consumed strictly in PHV arrival order.
REQ-023 lookup_valid with a non-empty FIFO pops the head PHV and reads the RAM at lookup_addr in that cycle.
REQ-024 Latency: lookup_valid at cycle N -> phv_out, action_out and both valids asserted at N+1 for exactly one cycle.
REQ-025 When lookup_hit=0, action_out is all zeros (no-op, so the crossbar passes containers through), and the RAM read is ignored.
REQ-026 When no pop occurs, phv_out_valid and action_out_valid are 0 and phv_out/action_out hold their last values.
REQ-027 Full FIFO + phv_in_valid + no pop: the PHV is dropped, the FIFO is unchanged, and err_overflow is set.
REQ-028 Full FIFO + phv_in_valid + pop in the same cycle: the push is accepted, fifo_count is unchanged, and no error is raised.
REQ-029 Empty FIFO + lookup_valid: no output, err_underflow is set; a PHV pushed in the same cycle is NOT popped (it becomes visible next cycle).
REQ-030 Read and write pointers wrap modulo FIFO_DEPTH; fifo_count ranges over 0..FIFO_DEPTH.
REQ-031 Action RAM write has 1-cycle effect; a read and a write to the same address in the same cycle returns the OLD data.
REQ-032 Action RAM contents are not reset; software writes every used entry before traffic.

Reset
REQ-033 Asserting rst_n clears FIFO pointers, fifo_count, both valids, phv_out, action_out, err_overflow and err_underflow to 0 immediately.
REQ-034 Reset mid-operation discards all held PHVs; the RAM retains its contents.

Configuration
REQ-035 With macro ACTION_FETCH_STATS_EN defined, the block adds 32-bit outputs hit_cnt and miss_cnt.
  - Each counter increments once per popped lookup, by hit or miss.
  - Counters saturate at 0xFFFFFFFF and reset to 0.
REQ-036 Without ACTION_FETCH_STATS_EN, the hit_cnt and miss_cnt ports and their logic are absent; all other behaviour is identical.

Verification
REQ-037 Write addr 3 = 625'h1ABC; PHV A pushed; 2 cycles later lookup hit addr 3 -> next cycle phv_out=A, action_out=625'h1ABC, both valids high for 1 cycle.
REQ-038 Push A,B,C; lookups miss, hit addr 0, hit addr 1 -> outputs in order A/zeros, B/RAM[0], C/RAM[1]; fifo_count goes 3,2,1,0.
REQ-039 Push 9 PHVs with no lookups -> fifo_count=8, err_overflow=1, and the 9th PHV never appears at the output.
REQ-040 FIFO full, push and lookup in the same cycle -> fifo_count stays 8, no error, and the oldest PHV is output.
REQ-041 lookup_valid on an empty FIFO -> err_underflow=1 and no valid output; then rst_n pulse mid-stream -> all outputs and flags 0, fifo_count=0.
REQ-042 Write addr 5 = X while reading addr 5 in the same cycle -> output carries the old value; the next lookup at addr 5 returns X; with ACTION_FETCH_STATS_EN, hit_cnt/miss_cnt match the issued counts.
